// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier and its sequencer.
package spm_pkg;

  localparam int SPM_N     = 8;   // operand width, fixed to the SPM width
  localparam int SPM_PW    = 16;  // product width = 2*N
  localparam int SPM_CNT_W = 5;   // holds 0..2N

  // Raw 2-bit state codes, shared with anything that decodes sequencer state.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_RUN   = ST_RUN,
    S_DONE  = ST_DONE
  } state_e;

  // Last RUN count: 2N multiplier bits plus one flush cycle for the SPM latency.
  localparam logic [SPM_CNT_W-1:0] RUN_LAST = SPM_CNT_W'(2 * SPM_N);

  // Sign-extend an operand to product width.
  function automatic logic [SPM_PW-1:0] sext_op(input logic [SPM_N-1:0] v);
    return {{(SPM_PW - SPM_N){v[SPM_N-1]}}, v};
  endfunction

endpackage

// File: rtl/spm.sv
// Serial-parallel multiplier: x is presented in parallel, y arrives one bit per
// cycle LSB-first, and product bits leave on p one cycle after the matching y bit.
// Only the sign of x is handled here; y must already be sign-extended by the caller.
module spm
  import spm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [SPM_N-1:0] x,
  input  logic             y,
  output logic             p
);

  // Two guard bits keep acc + x in range: acc stays within one x magnitude.
  localparam int AW = SPM_N + 2;

  logic [AW-1:0] acc_q, acc_d;
  logic          p_q, p_d;
  logic [AW-1:0] x_ext;
  logic [AW-1:0] sum;

  assign x_ext = {{(AW - SPM_N){x[SPM_N-1]}}, x};
  assign p     = p_q;

  // Add the gated partial product, emit the LSB, arithmetic-shift the rest down.
  always_comb begin
    sum   = acc_q + (y ? x_ext : '0);
    acc_d = {sum[AW-1], sum[AW-1:1]};
    p_d   = sum[0];
    if (clr) begin
      acc_d = '0;
      p_d   = 1'b0;
    end
  end

  // Accumulator and registered output bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      p_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      p_q   <= p_d;
    end
  end

endmodule

// File: rtl/spm_sequencer.sv
// Sequences one signed 8x8 -> 16-bit multiply through the SPM.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised by a producer, is held with stable data until that edge.
module spm_sequencer
  import spm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SPM_N-1:0]  a,
  input  logic [SPM_N-1:0]  b,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SPM_PW-1:0] product,
  output logic              busy
);

  state_e                 state_q, state_d;
  logic [SPM_CNT_W-1:0]   cnt_q, cnt_d;
  logic [SPM_N-1:0]       a_q, a_d;
  logic [SPM_PW-1:0]      b_q, b_d;
  logic [SPM_PW-1:0]      prod_q, prod_d;
  logic                   spm_clr;
  logic                   y_bit;
  logic                   spm_p;

  // The SPM sees rst directly so a reset mid-operation wipes its partial sums too.
  spm u_spm (
    .clk (clk),
    .rst (rst),
    .clr (spm_clr),
    .x   (a_q),
    .y   (y_bit),
    .p   (spm_p)
  );

  // Next-state, datapath updates and SPM drive.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    spm_clr = 1'b0;
    y_bit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sext_op(b);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        spm_clr = 1'b1;
        cnt_d   = '0;
        prod_d  = '0;
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // cnt=16 feeds a zero so the final product bit can drain out of the SPM.
        y_bit = (cnt_q < RUN_LAST) ? b_q[cnt_q[3:0]] : 1'b0;
        // p lags y by one cycle, so the bit seen at cnt=0 is not part of the product.
        if (cnt_q != '0) begin
          prod_d = {spm_p, prod_q[SPM_PW-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RUN_LAST) begin
          state_d = S_DONE;
        end
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          prod_d  = '0;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  // in_ready is masked by rst so nothing is offered while reset is held.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CLEAR) || (state_q == S_RUN);
  assign product   = out_valid ? prod_q : '0;

endmodule

// File: tb/tb_spm_sequencer.sv
// Directed and randomized checks of spm_sequencer against an arithmetic a*b model.
module tb_spm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];

  spm_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed product of two 8-bit two's complement numbers.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int px;
    int py;
    px = $signed(x);
    py = $signed(y);
    return 16'(px * py);
  endfunction

  // Waits for out_valid, bounded; returns cycles counted from the acceptance cycle.
  task automatic wait_done(output int n);
    n = 1;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  // One complete job with out_ready high; optional latency check.
  task automatic run_job(input logic [7:0] ja, input logic [7:0] jb,
                         input string tag, input bit chk_lat);
    int n;
    logic [15:0] e;
    check({tag, "_in_ready"}, in_ready, 1);
    a = ja;
    b = jb;
    in_valid = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(ref_mul(ja, jb));
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_done(n);
    if (chk_lat) check({tag, "_latency"}, n, 19);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_q_nonempty"}, exp_q.size() > 0, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check({tag, "_product"}, product, e);
    tick();
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int n;
    int cnt_v;
    int last;
    int got;
    bit pushed;
    logic [15:0] e;

    // ---- reset state ----
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);
    tick();

    // ---- directed products ----
    run_job(8'd3, 8'd5, "m3x5", 1'b1);
    run_job(8'h80, 8'h80, "mneg128sq", 1'b1);
    run_job(8'd127, 8'h80, "m127xneg128", 1'b0);
    run_job(8'hFF, 8'd1, "mneg1x1", 1'b0);
    check("m3x5_value", ref_mul(8'd3, 8'd5), 16'h000F);

    // ---- back-pressure in DONE ----
    out_ready = 1'b0;
    a = 8'd100;
    b = 8'hF6;
    in_valid = 1'b1;
    exp_q.push_back(ref_mul(8'd100, 8'hF6));
    tick();
    in_valid = 1'b0;
    wait_done(n);
    check("bp_latency", n, 19);
    e = exp_q.pop_front();
    a = 8'd5;
    b = 8'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_hold", out_valid, 1);
      check("bp_product_hold", product, e);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_not_busy", busy, 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_no_extra_job", busy, 0);

    // ---- abort at RUN cnt=7 ----
    a = 8'd50;
    b = 8'd50;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    cnt_v = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) cnt_v++;
      tick();
    end
    check("abort_no_valid", cnt_v, 0);
    run_job(8'd2, 8'hFD, "after_abort", 1'b1);

    // ---- asynchronous reset mid-RUN (cnt=9) ----
    a = 8'h9C;
    b = 8'd77;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_product", product, 0);
    check("arst_in_ready", in_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("arst_rel_ready", in_ready, 1);
    tick();
    check("arst_idle_busy", busy, 0);
    run_job(8'hF9, 8'd9, "after_rst", 1'b1);

    // ---- asynchronous reset while holding a result in DONE ----
    out_ready = 1'b0;
    a = 8'd11;
    b = 8'd13;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(n);
    check("done_rst_pre_product", product, ref_mul(8'd11, 8'd13));
    #2;
    rst = 1'b1;
    #1;
    check("done_rst_valid", out_valid, 0);
    check("done_rst_product", product, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // ---- randomized back-to-back stream ----
    last = -1;
    got = 0;
    n = 0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (got < 1000 && n < 25000) begin
      if (out_valid) begin
        check("rand_q_nonempty", exp_q.size() > 0, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("rand_product", product, e);
        if (last >= 0) check("rand_interval", n - last, 20);
        last = n;
        got++;
      end
      pushed = in_ready;
      if (pushed) exp_q.push_back(ref_mul(a, b));
      tick();
      n++;
      if (pushed) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
    end
    in_valid = 1'b0;
    check("rand_count", got, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
